serial_reg_bridge: RTL and testbench



---
 rtl/serial_pkg.sv | 26 ++
 rtl/uart_rx_core.sv | 85 ++++++++
 rtl/serial_reg_bridge.sv | 137 +++++++++++++
 tb/tb_serial_reg_bridge.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and parameter arithmetic for the serial register bridge.
// No logic, no latency; no backpressure.
package serial_pkg;

    typedef enum logic {WAIT_ADDR, WAIT_DATA} frame_state_t;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    function automatic int calc_div(input int osc, input int baud);
        return osc / baud;
    endfunction

    function automatic int calc_tmo(input int bits, input int div);
        return bits * div;
    endfunction

    function automatic int calc_link(input int ms, input int osc);
        return int'((longint'(ms) * longint'(osc)) / 64'sd1000);
    endfunction

    // Width able to hold 0..maxv, never zero bits.
    function automatic int cnt_w(input int maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 byte receiver on a synchronised line; pulses are combinational on the sample cycle.
// Latency: stop sample at DIV/2 + 9*DIV after start detect; no backpressure, bytes are not held.
import serial_pkg::*;

module uart_rx_core #(
    parameter int DIV = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_sync,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_ferr,
    output logic       rx_start
);
    localparam int HALF = DIV / 2;
    localparam int CW   = cnt_w(DIV - 1);

    rx_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_sh;
    logic        r_wait_hi;
    logic        w_tick_half;
    logic        w_tick_full;

    assign w_tick_half = (r_cnt == CW'(HALF - 1));
    assign w_tick_full = (r_cnt == CW'(DIV - 1));
    assign byte_out    = r_sh;
    assign byte_valid  = (r_state == STOP)  && w_tick_full &&  rx_sync;
    assign byte_ferr   = (r_state == STOP)  && w_tick_full && !rx_sync;
    assign rx_start    = (r_state == START) && w_tick_half && !rx_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
            r_wait_hi <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    // After a bad stop bit the line must return high before re-arming.
                    if (r_wait_hi) begin
                        if (rx_sync) r_wait_hi <= 1'b0;
                    end else if (!rx_sync) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_tick_half) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= rx_sync ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick_full) begin
                        r_cnt <= '0;
                        r_sh  <= {rx_sync, r_sh[7:1]};
                        if (r_bit == 3'd7) r_state <= STOP;
                        else               r_bit   <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick_full) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        if (!rx_sync) r_wait_hi <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/serial_reg_bridge.sv
// UART address/data frames to one-cycle register-write strobes, with timeout, error flag and status LEDs.
// Latency: reg_we one cycle after the data-byte stop sample; no backpressure, the host must pace frames.
import serial_pkg::*;

module serial_reg_bridge #(
    parameter int OSCRATE      = 12_000_000,
    parameter int BAUDRATE     = 9600,
    parameter int ADDR_W       = 5,
    parameter int TIMEOUT_BITS = 20,
    parameter int LINK_MS      = 50
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_data,
    output logic              reg_we,
    output logic              link,
    output logic              blink,
    output logic              frame_err
);
    localparam int DIV = calc_div(OSCRATE, BAUDRATE);
    localparam int TMO = calc_tmo(TIMEOUT_BITS, DIV);
    localparam int LNK = calc_link(LINK_MS, OSCRATE);
    localparam int BLK = OSCRATE / 2;
    localparam int TW  = cnt_w(TMO);
    localparam int LW  = cnt_w(LNK);
    localparam int BW  = cnt_w(BLK);

    logic              r_rx_meta;
    logic              r_rx_sync;
    frame_state_t      r_fsm;
    logic [ADDR_W-1:0] r_addr_lat;
    logic [TW-1:0]     r_tmo_cnt;
    logic              r_tmo_arm;
    logic [LW-1:0]     r_link_cnt;
    logic [BW-1:0]     r_blk_cnt;
    logic              r_blink;
    logic [7:0]        w_byte;
    logic              w_byte_vld;
    logic              w_byte_ferr;
    logic              w_rx_start;
    logic              w_tmo_exp;
    logic              w_in_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    uart_rx_core #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_sync    (r_rx_sync),
        .byte_out   (w_byte),
        .byte_valid (w_byte_vld),
        .byte_ferr  (w_byte_ferr),
        .rx_start   (w_rx_start)
    );

    // An expiring timeout wins; a byte completing on that cycle is treated as an address byte.
    assign w_tmo_exp = (r_fsm == WAIT_DATA) && r_tmo_arm && (r_tmo_cnt == TW'(TMO - 1));
    assign w_in_addr = (r_fsm == WAIT_ADDR) || w_tmo_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm      <= WAIT_ADDR;
            r_addr_lat <= '0;
            r_tmo_cnt  <= '0;
            r_tmo_arm  <= 1'b0;
            reg_addr   <= '0;
            reg_data   <= '0;
            reg_we     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            if (r_fsm == WAIT_DATA && r_tmo_arm) begin
                if (w_rx_start)      r_tmo_arm <= 1'b0;
                else if (!w_tmo_exp) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_tmo_exp) begin
                r_fsm     <= WAIT_ADDR;
                r_tmo_arm <= 1'b0;
                frame_err <= 1'b1;
            end
            if (w_byte_vld) begin
                if (w_in_addr) begin
                    if (w_byte[7]) begin
                        r_addr_lat <= w_byte[ADDR_W-1:0];
                        r_fsm      <= WAIT_DATA;
                        r_tmo_cnt  <= '0;
                        r_tmo_arm  <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end else begin
                    reg_addr  <= r_addr_lat;
                    reg_data  <= w_byte;
                    reg_we    <= 1'b1;
                    r_fsm     <= WAIT_ADDR;
                    r_tmo_arm <= 1'b0;
                    frame_err <= 1'b0;
                end
            end else if (w_byte_ferr) begin
                r_fsm     <= WAIT_ADDR;
                r_tmo_arm <= 1'b0;
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link_cnt <= '0;
            r_blk_cnt  <= '0;
            r_blink    <= 1'b0;
        end else begin
            if (w_byte_vld)             r_link_cnt <= LW'(LNK);
            else if (r_link_cnt != '0)  r_link_cnt <= r_link_cnt - 1'b1;
            if (r_blk_cnt == BW'(BLK - 1)) begin
                r_blk_cnt <= '0;
                r_blink   <= ~r_blink;
            end else begin
                r_blk_cnt <= r_blk_cnt + 1'b1;
            end
        end
    end

    assign link  = (r_link_cnt != '0);
    assign blink = r_blink;

endmodule

// File: tb/tb_serial_reg_bridge.sv
// Directed bench: frame table plus glitch, timeout, link-hold, reset-mid-byte and heartbeat sequences.
module tb_serial_reg_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rx;
    logic [4:0] reg_addr;
    logic [7:0] reg_data;
    logic       reg_we, link, blink, frame_err;
    logic [4:0] b_addr;
    logic [7:0] b_data;
    logic       b_we, b_link, b_blink, b_ferr;
    logic       b_rx;

    serial_reg_bridge #(.OSCRATE(1_600_000), .BAUDRATE(100_000), .ADDR_W(5),
                        .TIMEOUT_BITS(20), .LINK_MS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .reg_addr(reg_addr), .reg_data(reg_data),
        .reg_we(reg_we), .link(link), .blink(blink), .frame_err(frame_err));

    // Scaled clock so the heartbeat period is observable in a short run (half period 32 cycles).
    serial_reg_bridge #(.OSCRATE(64), .BAUDRATE(4), .ADDR_W(5),
                        .TIMEOUT_BITS(20), .LINK_MS(1)) dut_blk (
        .clk(clk), .rst_n(rst_n), .rx(b_rx), .reg_addr(b_addr), .reg_data(b_data),
        .reg_we(b_we), .link(b_link), .blink(b_blink), .frame_err(b_ferr));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cnt = 0;
    int we_cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_we === 1'b1) begin
            we_cnt <= we_cnt + 1;
            we_cyc <= cyc;
        end
    end

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic       has_b1;
        logic       stop1;
        int         exp_we;
        logic [4:0] exp_addr;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        rx = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(16);
        end
        rx = stop_v;
        idle(16);
        rx = 1'b1;
    endtask

    initial begin
        int n0, t0, t1, t2, t3;
        vt[0] = '{8'h95, 8'h0F, 1'b1, 1'b1, 1, 5'h15, 8'h0F, 1'b0};
        vt[1] = '{8'h12, 8'h00, 1'b0, 1'b1, 0, 5'h15, 8'h0F, 1'b1};
        vt[2] = '{8'h83, 8'hAA, 1'b1, 1'b1, 1, 5'h03, 8'hAA, 1'b0};
        vt[3] = '{8'hE4, 8'h00, 1'b1, 1'b1, 1, 5'h04, 8'h00, 1'b0};
        vt[4] = '{8'h81, 8'h55, 1'b1, 1'b0, 0, 5'h04, 8'h00, 1'b1};
        vt[5] = '{8'h9F, 8'h80, 1'b1, 1'b1, 1, 5'h1F, 8'h80, 1'b0};

        rst_n = 1'b0;
        rx    = 1'b1;
        b_rx  = 1'b1;
        idle(3);
        @(negedge clk);
        chk("rst_addr", reg_addr, 5'h00);
        chk("rst_data", reg_data, 8'h00);
        chk("rst_we", reg_we, 1'b0);
        chk("rst_link", link, 1'b0);
        chk("rst_blink", blink, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_blink2", b_blink, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t0 = cyc;

        // Heartbeat on the scaled instance: 32-cycle half period from reset.
        for (int i = 0; i < 200 && b_blink !== 1'b1; i++) @(negedge clk);
        t1 = cyc;
        chk("blink_first", (t1 - t0 >= 31 && t1 - t0 <= 33), 1'b1);
        for (int i = 0; i < 200 && b_blink !== 1'b0; i++) @(negedge clk);
        t2 = cyc;
        chk("blink_half1", t2 - t1, 32);
        for (int i = 0; i < 200 && b_blink !== 1'b1; i++) @(negedge clk);
        t3 = cyc;
        chk("blink_half2", t3 - t2, 32);

        // 8-cycle low glitch must not start a byte.
        @(posedge clk);
        #1;
        rx = 1'b0;
        idle(8);
        rx = 1'b1;
        idle(300);
        chk("glitch_we", we_cnt, 0);
        chk("glitch_link", link, 1'b0);
        chk("glitch_ferr", frame_err, 1'b0);

        for (int i = 0; i < 6; i++) begin
            n0 = we_cnt;
            send_byte(vt[i].b0, 1'b1);
            if (vt[i].has_b1) send_byte(vt[i].b1, vt[i].stop1);
            idle(40);
            chk($sformatf("v%0d_we", i), we_cnt - n0, vt[i].exp_we);
            chk($sformatf("v%0d_addr", i), reg_addr, vt[i].exp_addr);
            chk($sformatf("v%0d_data", i), reg_data, vt[i].exp_data);
            chk($sformatf("v%0d_ferr", i), frame_err, vt[i].exp_ferr);
            if (vt[i].exp_we == 1)
                chk($sformatf("v%0d_lat", i),
                    (we_cyc - start_cyc >= 153 && we_cyc - start_cyc <= 157), 1'b1);
        end

        // Link holds 1600 cycles after the last good byte.
        while (cyc < we_cyc + 1500) @(negedge clk);
        chk("link_hold", link, 1'b1);
        while (cyc < we_cyc + 1700) @(negedge clk);
        chk("link_drop", link, 1'b0);

        // Address then 21 idle bit times: timeout after 20.
        n0 = we_cnt;
        send_byte(8'h81, 1'b1);
        idle(290);
        chk("tmo_early", frame_err, 1'b0);
        idle(40);
        chk("tmo_late", frame_err, 1'b1);
        idle(6);
        send_byte(8'h55, 1'b1);
        idle(40);
        chk("tmo_we", we_cnt - n0, 0);
        chk("tmo_ferr", frame_err, 1'b1);

        // Reset in the middle of a data byte.
        send_byte(8'h90, 1'b1);
        @(posedge clk);
        #1;
        rx = 1'b0;
        idle(64);
        rst_n = 1'b0;
        rx = 1'b1;
        idle(3);
        chk("mrst_ferr", frame_err, 1'b0);
        chk("mrst_link", link, 1'b0);
        chk("mrst_addr", reg_addr, 5'h00);
        chk("mrst_data", reg_data, 8'h00);
        rst_n = 1'b1;
        idle(20);
        n0 = we_cnt;
        send_byte(8'h84, 1'b1);
        send_byte(8'h33, 1'b1);
        idle(40);
        chk("post_we", we_cnt - n0, 1);
        chk("post_addr", reg_addr, 5'h04);
        chk("post_data", reg_data, 8'h33);
        chk("post_ferr", frame_err, 1'b0);
        chk("blink_main", blink, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
